bht_predictor: RTL and testbench
================================

Name: bht_predictor

Overview:
- Branch history table on the read side of the predictor. It is indexed by the fetch PC and returns a 1-cycle-latency taken/not-taken guess.
- It stores one 2-bit counter per line. Each counter is updated by resolved branch outcomes from execute.
- It has an internal clear sequencer, so a context switch or flush can reinitialise the table without a global reset.

Parameters:
- LINES, 32, number of counter entries; power of two, at least 2. IDX = $clog2(LINES).
- PC_WIDTH, 32, width of both PC inputs.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- guess_pc  input  PC_WIDTH  fetch PC to predict
- guess_valid  input  1  lookup request this cycle
- pred_valid  output  1  registered; pred_taken is meaningful
- pred_taken  output  1  registered prediction for the previous-cycle lookup
- check_pc  input  PC_WIDTH  PC of the resolved branch
- check_valid  input  1  resolved branch this cycle
- check_taken  input  1  actual outcome: 1 = taken, 0 = not taken
- clear  input  1  start the table reinitialise sequence (pulse)
- busy  output  1  high while the clear sequence runs

Behaviour:
- Index: idx = pc[IDX+1:2] for both ports. Bits [1:0] and bits above IDX+1 are ignored, so aliasing is allowed.
- Counter encoding:
  - 11 = strong taken, 10 = weak taken, 00 = weak not-taken, 01 = strong not-taken.
  - Prediction = counter MSB.
- Update on taken: 00->11, 01->00, 10->11, 11->11.
- Update on not-taken: 00->01, 01->01, 10->01, 11->10.
- Reset (rst_n = 0, asynchronous):
  - All entries = 01.
  - pred_valid = 0, pred_taken = 0, busy = 0.
  - FSM = IDLE, clear pointer = 0.
- FSM state IDLE:
  - Lookup: at the rising edge, pred_valid <= guess_valid and pred_taken <= guess_valid & MSB(entry[idx]). Latency is 1 cycle.
  - Update: if check_valid, entry[check_idx] is written with its updated value at the same edge.
  - Same-index collision: if guess_valid and check_valid hit the same idx in one cycle, pred_taken uses the updated counter MSB (write-first bypass).
- IDLE -> CLEAR when clear = 1 at an edge.
  - busy rises on that edge.
  - Pointer starts at 0.
  - check_valid in that same cycle is dropped.
  - guess_valid in that same cycle is still served.
- FSM state CLEAR:
  - Each cycle writes 01 to entry[ptr], then ptr increments.
  - After writing entry LINES-1: ptr wraps to 0, FSM returns to IDLE and busy falls. CLEAR therefore lasts exactly LINES cycles.
  - Lookups: pred_valid <= guess_valid, pred_taken <= 0.
  - check_valid is ignored; no counter changes.
  - clear asserted again during CLEAR is ignored; the sequence does not restart.
- pred_* hold their value when no edge-qualified event occurs. They are refreshed every edge from guess_valid.
- rst_n asserted mid-CLEAR aborts the sequence immediately and applies full reset values.
- Two checks cannot occur in one cycle (single update port). Consecutive-cycle checks to the same idx must chain, each reading the previously written value.

Test Plan:
- Reset, then guess_pc = 0x0000_0010, guess_valid = 1 -> next cycle pred_valid = 1, pred_taken = 0 (entry = 01).
- Three checks on 0x10: taken, taken, not-taken -> counter 01->00->11->10. A lookup after each check gives pred_taken 0, 1, 1.
- Same cycle, check_pc = guess_pc = 0x24, entry = 00, check_taken = 1 -> pred_taken = 1 next cycle (bypass). Entry = 11.
- Alias: set counter of 0x0000_0004 to 11, then look up 0x0000_0084 (LINES = 32) -> pred_taken = 1. Look up 0x0000_0086 -> pred_taken = 1 (low bits ignored).
- Train 0x08 to 11, pulse clear -> busy high for exactly 32 cycles. check_valid during CLEAR is ignored, and lookups return 0. After busy falls, 0x08 predicts 0.
- Deassert rst_n for 1 cycle at cycle 10 of CLEAR -> busy = 0 immediately and all entries = 01. A following clear pulse runs the full 32 cycles again.

Source files
------------

// File: rtl/bht_predictor.sv
// Branch history table: one 2-bit counter per line, indexed by PC word address,
// 1-cycle lookup with write-first bypass and a line-at-a-time clear sequencer.
module bht_predictor #(
    parameter int LINES    = 32,
    parameter int PC_WIDTH = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [PC_WIDTH-1:0] guess_pc,
    input  logic                guess_valid,
    output logic                pred_valid,
    output logic                pred_taken,
    input  logic [PC_WIDTH-1:0] check_pc,
    input  logic                check_valid,
    input  logic                check_taken,
    input  logic                clear,
    output logic                busy
);
    localparam int IDX = $clog2(LINES);
    localparam logic [1:0] CTR_INIT = 2'b01;

    typedef enum logic {IDLE, CLEAR} state_t;

    state_t         state, state_nxt;
    logic [IDX-1:0] ptr, ptr_nxt;
    logic [1:0]     ctr_mem [LINES];
    logic [IDX-1:0] guess_idx, check_idx;
    logic           upd_en;
    logic [1:0]     upd_val;
    logic           taken_nxt;
    logic           unused_pc_bits;

    // Weak states jump straight to the opposite strong state on a misprediction.
    function automatic logic [1:0] next_ctr(input logic [1:0] ctr, input logic taken);
        logic [1:0] res;
        if (taken) begin
            res = (ctr == 2'b01) ? 2'b00 : 2'b11;
        end else begin
            res = (ctr == 2'b11) ? 2'b10 : 2'b01;
        end
        return res;
    endfunction

    assign guess_idx      = guess_pc[IDX+1:2];
    assign check_idx      = check_pc[IDX+1:2];
    assign unused_pc_bits = ^{guess_pc[PC_WIDTH-1:IDX+2], guess_pc[1:0],
                              check_pc[PC_WIDTH-1:IDX+2], check_pc[1:0]};

    // A check arriving in the same cycle as the clear request is dropped.
    assign upd_en  = (state == IDLE) && check_valid && !clear;
    assign upd_val = next_ctr(ctr_mem[check_idx], check_taken);
    assign busy    = (state == CLEAR);

    always_comb begin
        state_nxt = state;
        ptr_nxt   = ptr;
        taken_nxt = 1'b0;
        case (state)
            IDLE: begin
                if (guess_valid) begin
                    taken_nxt = (upd_en && (check_idx == guess_idx)) ? upd_val[1]
                                                                     : ctr_mem[guess_idx][1];
                end
                if (clear) begin
                    state_nxt = CLEAR;
                    ptr_nxt   = '0;
                end
            end
            CLEAR: begin
                ptr_nxt = ptr + IDX'(1);
                if (ptr == IDX'(LINES - 1)) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
                ptr_nxt   = '0;
            end
        endcase
    end

    // Stage p0 -> p1: control state and registered prediction
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            ptr        <= '0;
            pred_valid <= 1'b0;
            pred_taken <= 1'b0;
        end else begin
            state      <= state_nxt;
            ptr        <= ptr_nxt;
            pred_valid <= guess_valid;
            pred_taken <= taken_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < LINES; i++) begin
                ctr_mem[i] <= CTR_INIT;
            end
        end else if (state == CLEAR) begin
            ctr_mem[ptr] <= CTR_INIT;
        end else if (upd_en) begin
            ctr_mem[check_idx] <= upd_val;
        end
    end
endmodule

// File: tb/tb_bht_predictor.sv
// Scoreboard bench for bht_predictor: a level-based reference model queues expected
// predictions at issue time; a negedge monitor pops them whenever pred_valid is high.
module tb_bht_predictor;
    localparam int LINES    = 32;
    localparam int PC_WIDTH = 32;

    logic                clk = 1'b0;
    logic                rst_n;
    logic [PC_WIDTH-1:0] guess_pc;
    logic                guess_valid;
    logic                pred_valid;
    logic                pred_taken;
    logic [PC_WIDTH-1:0] check_pc;
    logic                check_valid;
    logic                check_taken;
    logic                clear;
    logic                busy;

    bht_predictor #(.LINES(LINES), .PC_WIDTH(PC_WIDTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .guess_pc(guess_pc), .guess_valid(guess_valid),
        .pred_valid(pred_valid), .pred_taken(pred_taken),
        .check_pc(check_pc), .check_valid(check_valid), .check_taken(check_taken),
        .clear(clear), .busy(busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference: confidence level 0 = strong NT, 1 = weak NT, 2 = weak T, 3 = strong T.
    int lvl [LINES];
    int clr_left;
    bit exp_q [$];

    function automatic int line_of(input logic [PC_WIDTH-1:0] pc);
        return int'((pc >> 2) % LINES);
    endfunction

    function automatic int learn(input int l, input bit taken);
        if (taken) return (l == 0) ? 1 : 3;
        return (l == 3) ? 2 : 0;
    endfunction

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, req);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < LINES; i++) lvl[i] = 0;
        clr_left = 0;
        exp_q.delete();
    endtask

    // Entered and left 1 time unit after a rising edge.
    task automatic step(input bit gv, input logic [PC_WIDTH-1:0] gpc,
                        input bit cv, input logic [PC_WIDTH-1:0] cpc,
                        input bit ct, input bit clr);
        int gi;
        int ci;
        int nl;
        check("busy", int'(busy), int'(clr_left > 0));
        guess_valid = gv; guess_pc = gpc;
        check_valid = cv; check_pc = cpc; check_taken = ct;
        clear = clr;
        gi = line_of(gpc);
        ci = line_of(cpc);
        if (clr_left == 0) begin
            nl = learn(lvl[ci], ct);
            if (gv) exp_q.push_back((cv && !clr && ci == gi) ? (nl >= 2) : (lvl[gi] >= 2));
            if (cv && !clr) lvl[ci] = nl;
            if (clr) begin
                clr_left = LINES;
                for (int i = 0; i < LINES; i++) lvl[i] = 0;
            end
        end else begin
            if (gv) exp_q.push_back(1'b0);
            clr_left--;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        step(0, '0, 0, '0, 0, 0);
    endtask

    task automatic do_reset();
        guess_valid = 0; check_valid = 0; clear = 0;
        rst_n = 1'b0;
        #1;
        model_reset();
        check("rst_busy", int'(busy), 0);
        check("rst_pred_valid", int'(pred_valid), 0);
        check("rst_pred_taken", int'(pred_taken), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    always @(negedge clk) begin
        if (rst_n === 1'b1 && pred_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_pred_valid", 1, 0);
            end else begin
                check("pred_taken", int'(pred_taken), int'(exp_q.pop_front()));
            end
        end
    end

    initial begin
        guess_valid = 0; guess_pc = '0;
        check_valid = 0; check_pc = '0; check_taken = 0;
        clear = 0;
        rst_n = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("init_busy", int'(busy), 0);
        check("init_pred_valid", int'(pred_valid), 0);
        rst_n = 1'b1;

        // Lookup of an untouched line, then taken/taken/not-taken with lookups between.
        step(1, 32'h10, 0, '0, 0, 0);
        step(0, '0, 1, 32'h10, 1, 0); step(1, 32'h10, 0, '0, 0, 0);
        step(0, '0, 1, 32'h10, 1, 0); step(1, 32'h10, 0, '0, 0, 0);
        step(0, '0, 1, 32'h10, 0, 0); step(1, 32'h10, 0, '0, 0, 0);

        // Same-cycle collision on a weak not-taken line must see the update.
        step(0, '0, 1, 32'h24, 1, 0);
        step(1, 32'h24, 1, 32'h24, 1, 0);
        step(1, 32'h24, 0, '0, 0, 0);

        // Aliasing through ignored high and low PC bits.
        step(0, '0, 1, 32'h4, 1, 0); step(0, '0, 1, 32'h4, 1, 0);
        step(1, 32'h84, 0, '0, 0, 0);
        step(1, 32'h86, 0, '0, 0, 0);

        // Full clear: checks dropped, lookups zero, busy for exactly LINES cycles.
        step(0, '0, 1, 32'h8, 1, 0); step(0, '0, 1, 32'h8, 1, 0);
        step(1, 32'h8, 0, '0, 0, 0);
        step(1, 32'h8, 1, 32'h8, 1, 1);
        for (int i = 0; i < LINES; i++) step(1, 32'h8, 1, 32'h8, 1, (i == 5));
        step(1, 32'h8, 0, '0, 0, 0);
        idle();

        // Reset in the middle of a clear, then a complete clear afterwards.
        step(0, '0, 1, 32'h8, 1, 0); step(0, '0, 1, 32'h8, 1, 0);
        step(0, '0, 0, '0, 0, 1);
        for (int i = 0; i < 10; i++) idle();
        do_reset();
        step(1, 32'h8, 0, '0, 0, 0);
        step(0, '0, 1, 32'h8, 1, 0); step(0, '0, 1, 32'h8, 1, 0);
        step(0, '0, 0, '0, 0, 1);
        for (int i = 0; i < LINES; i++) step(1, 32'h8, 0, '0, 0, 0);
        step(1, 32'h8, 0, '0, 0, 0);

        // Randomised traffic over a small PC window to force collisions and chaining.
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 599) == 0) begin
                do_reset();
            end else begin
                step($urandom_range(0, 3) != 0, PC_WIDTH'($urandom_range(0, 511)),
                     $urandom_range(0, 2) != 0, PC_WIDTH'($urandom_range(0, 511)),
                     $urandom_range(0, 1) == 1, $urandom_range(0, 149) == 0);
            end
        end
        idle();
        idle();
        check("scoreboard_drained", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
